// File: rtl/cc_pkg.sv
// Shared definitions for the cache-miss request path: AXI read constants,
// miss-address field positions and the request FSM state type.
package cc_pkg;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [3:0] LINE_ARLEN     = 4'd7;

  // Miss-address fields: tag, set index and 64-bit word offset within the line.
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 15;
  localparam int IDX_MSB  = 14;
  localparam int IDX_LSB  = 6;
  localparam int WOFF_MSB = 5;
  localparam int WOFF_LSB = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_AR_REQ = 1'b1
  } cc_state_e;

  // WRAP bursts start at the critical 64-bit word, so only byte bits are cleared.
  function automatic logic [31:0] beat_align(input logic [31:0] addr);
    return {addr[31:WOFF_LSB], {WOFF_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/cc_miss_req_unit.sv
// Turns accepted cache misses into critical-word-first AXI WRAP read bursts,
// pushes each miss address to the fill-stage FIFO and limits bursts in flight.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_req_valid_i,
  input  logic [31:0]      miss_req_addr_i,
  output logic             miss_req_ready_o,
  output logic             mem_arvalid_o,
  output logic [31:0]      mem_araddr_o,
  output logic [3:0]       mem_arlen_o,
  output logic [2:0]       mem_arsize_o,
  output logic [1:0]       mem_arburst_o,
  input  logic             mem_arready_i,
  input  logic             mem_rvalid_i,
  input  logic             mem_rready_i,
  input  logic             mem_rlast_i,
  input  logic             miss_addr_fifo_full_i,
  output logic             miss_addr_fifo_wren_o,
  output logic [31:0]      miss_addr_fifo_wdata_o,
  output logic [CNT_W-1:0] outstanding_o,
  output cc_state_e        dbg_state_o
);

  // Handshakes: a miss is taken when miss_req_valid_i & miss_req_ready_o, an AR
  // burst leaves when mem_arvalid_o & mem_arready_i, and a burst retires when
  // mem_rvalid_i & mem_rready_i & mem_rlast_i; arvalid stays high until taken.

  cc_state_e        r_state;
  cc_state_e        w_state_nxt;
  logic [31:0]      r_araddr;
  logic [CNT_W-1:0] r_outst;
  logic             w_ready;
  logic             w_accept;
  logic             w_ar_hs;
  logic             w_rlast_hs;

  assign w_ar_hs    = (r_state == ST_AR_REQ) && mem_arready_i;
  assign w_rlast_hs = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst_n gating keeps ready low for the whole time reset is held.
        w_ready  = rst_n && (r_outst < CNT_W'(MAX_OUTSTANDING)) && !miss_addr_fifo_full_i;
        w_accept = w_ready && miss_req_valid_i;
        if (w_accept) w_state_nxt = ST_AR_REQ;
      end
      ST_AR_REQ: begin
        if (mem_arready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_araddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_araddr <= beat_align(miss_req_addr_i);
    end
  end

  // Issue and retire in the same cycle cancel; a stray RLAST at zero is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else begin
      case ({w_ar_hs, w_rlast_hs})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   if (r_outst != '0) r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign miss_req_ready_o       = w_ready;
  assign miss_addr_fifo_wren_o  = w_accept;
  assign miss_addr_fifo_wdata_o = miss_req_addr_i;
  assign mem_arvalid_o          = rst_n && (r_state == ST_AR_REQ);
  assign mem_araddr_o           = r_araddr;
  assign mem_arlen_o            = LINE_ARLEN;
  assign mem_arsize_o           = AXI_SIZE_8B;
  assign mem_arburst_o          = AXI_BURST_WRAP;
  assign outstanding_o          = r_outst;
  assign dbg_state_o            = r_state;

  a_araddr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_arvalid_o && !mem_arready_i) |=> $stable(mem_araddr_o));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    miss_addr_fifo_wren_o |-> !miss_addr_fifo_full_i);
  a_outst_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    r_outst <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Bench for cc_miss_req_unit: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level model.
module tb_cc_miss_req_unit;
  import cc_pkg::*;

  localparam int MAX   = 4;
  localparam int CNT_W = $clog2(MAX + 1);

  logic             clk;
  logic             rst_n;
  logic             valid;
  logic [31:0]      addr;
  logic             ready;
  logic             arvalid;
  logic [31:0]      araddr;
  logic [3:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic             arready;
  logic             rvalid;
  logic             rready;
  logic             rlast;
  logic             full;
  logic             wren;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] outst;
  cc_state_e        dbg_state;

  int checks   = 0;
  int failures = 0;

  cc_miss_req_unit #(.MAX_OUTSTANDING(MAX)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_valid_i       (valid),
    .miss_req_addr_i        (addr),
    .miss_req_ready_o       (ready),
    .mem_arvalid_o          (arvalid),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arready_i          (arready),
    .mem_rvalid_i           (rvalid),
    .mem_rready_i           (rready),
    .mem_rlast_i            (rlast),
    .miss_addr_fifo_full_i  (full),
    .miss_addr_fifo_wren_o  (wren),
    .miss_addr_fifo_wdata_o (wdata),
    .outstanding_o          (outst),
    .dbg_state_o            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // RLAST with nothing in flight is a memory-side protocol error.
  a_rlast_needs_burst: assert property (@(posedge clk) disable iff (!rst_n)
    (rvalid && rready && rlast) |-> (outst != '0));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A miss is "pending" from its acceptance until its AR is taken; exp_q holds
  // the FIFO-pushed addresses whose AR has not been issued yet, in push order.
  logic [31:0] exp_q[$];
  bit          m_pending;
  int          m_outst;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_outst   <= 0;
      exp_q.delete();
    end else begin
      bit acc, inc, dec;
      acc = !m_pending && (m_outst < MAX) && !full && valid;
      inc = m_pending && arready;
      dec = rvalid && rready && rlast;
      if (inc) begin
        void'(exp_q.pop_front());
        m_pending <= 1'b0;
      end
      if (acc) begin
        exp_q.push_back(addr);
        m_pending <= 1'b1;
      end
      if (inc && !dec) m_outst <= m_outst + 1;
      else if (!inc && dec && m_outst > 0) m_outst <= m_outst - 1;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    bit          e_ready;
    bit          e_wren;
    logic [31:0] head;
    chk("arlen", 32'(arlen), 32'd7);
    chk("arsize", 32'(arsize), 32'd3);
    chk("arburst", 32'(arburst), 32'd2);
    if (!rst_n) begin
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_wren", 32'(wren), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_outst", 32'(outst), 32'd0);
    end else begin
      e_ready = !m_pending && (m_outst < MAX) && !full;
      e_wren  = e_ready && valid;
      chk("sb_ready", 32'(ready), 32'(e_ready));
      chk("sb_wren", 32'(wren), 32'(e_wren));
      chk("sb_arvalid", 32'(arvalid), 32'(m_pending));
      chk("sb_outst", 32'(outst), 32'(m_outst));
      chk("sb_state", 32'(dbg_state == ST_AR_REQ), 32'(m_pending));
      if (e_wren) chk("sb_wdata", wdata, addr);
      if (m_pending && exp_q.size() > 0) begin
        head = exp_q[0];
        chk("sb_araddr", araddr, {head[31:3], 3'b000});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic rlast_pulse();
    tick();
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  // Accept one miss, then let its AR be taken on the first AR_REQ cycle.
  task automatic issue_miss(input logic [31:0] a, input bit with_rlast);
    tick();
    valid = 1'b1; addr = a; arready = 1'b0;
    tick();
    valid = 1'b0; arready = 1'b1;
    if (with_rlast) begin rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; end
    tick();
    arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_acc;
    int n_hs;
    rst_n = 1'b0; valid = 1'b0; addr = '0; arready = 1'b0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; full = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Single miss with AR held for three cycles, then an 8-beat R burst.
    mid();
    chk("t1_idle_outst", 32'(outst), 32'd0);
    tick();
    valid = 1'b1; addr = 32'h0001_2368;
    mid();
    chk("t1_wren", 32'(wren), 32'd1);
    chk("t1_wdata", wdata, 32'h0001_2368);
    chk("t1_arvalid_pre", 32'(arvalid), 32'd0);
    tick();
    valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) arready = 1'b1;
      mid();
      chk("t1_arvalid", 32'(arvalid), 32'd1);
      chk("t1_araddr", araddr, 32'h0001_2368);
      chk("t1_ready_busy", 32'(ready), 32'd0);
      tick();
    end
    arready = 1'b0;
    mid();
    chk("t1_outst_1", 32'(outst), 32'd1);
    for (int b = 0; b < 8; b++) begin
      tick();
      rvalid = 1'b1; rready = 1'b1; rlast = (b == 7);
    end
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    mid();
    chk("t1_outst_0", 32'(outst), 32'd0);

    // Unaligned miss address.
    tick();
    valid = 1'b1; addr = 32'h0000_0047;
    mid();
    chk("t2_wdata", wdata, 32'h0000_0047);
    tick();
    valid = 1'b0; arready = 1'b1;
    mid();
    chk("t2_araddr", araddr, 32'h0000_0040);
    tick();
    arready = 1'b0;
    rlast_pulse();

    // Throttle at MAX outstanding with no R traffic.
    n_acc = 0; n_hs = 0;
    arready = 1'b1; valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      addr = 32'h1000_0000 + 32'(c * 64);
      mid();
      if (wren) n_acc++;
      if (arvalid && arready) n_hs++;
      tick();
    end
    mid();
    chk("t3_accepts", 32'(n_acc), 32'd4);
    chk("t3_ars", 32'(n_hs), 32'd4);
    chk("t3_ready_low", 32'(ready), 32'd0);
    chk("t3_outst_max", 32'(outst), 32'd4);
    tick();
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    mid();
    chk("t3_ready_same_cycle", 32'(ready), 32'd0);
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    mid();
    chk("t3_ready_next", 32'(ready), 32'd1);
    chk("t3_fifth_push", 32'(wren), 32'd1);
    tick();
    valid = 1'b0;
    tick();
    arready = 1'b0;
    mid();
    chk("t3_outst_refill", 32'(outst), 32'd4);
    for (int i = 0; i < 4; i++) rlast_pulse();

    // FIFO full holds off acceptance.
    tick();
    full = 1'b1; valid = 1'b1; addr = 32'hABCD_0128;
    for (int c = 0; c < 10; c++) begin
      mid();
      chk("t4_no_push", 32'(wren), 32'd0);
      chk("t4_no_ar", 32'(arvalid), 32'd0);
      tick();
    end
    full = 1'b0;
    mid();
    chk("t4_push_after_full", 32'(wren), 32'd1);
    tick();
    valid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rlast_pulse();

    // AR handshake coinciding with RLAST at outstanding=2.
    issue_miss(32'h2000_0008, 1'b0);
    issue_miss(32'h2000_0010, 1'b0);
    mid();
    chk("t5_outst_2", 32'(outst), 32'd2);
    issue_miss(32'h2000_0018, 1'b1);
    mid();
    chk("t5_outst_same", 32'(outst), 32'd2);

    // Asynchronous reset while an AR is pending.
    tick();
    valid = 1'b1; addr = 32'h3000_0020;
    tick();
    valid = 1'b0;
    mid();
    chk("t6_arvalid_before", 32'(arvalid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_arvalid_rst", 32'(arvalid), 32'd0);
    chk("t6_wren_rst", 32'(wren), 32'd0);
    chk("t6_outst_rst", 32'(outst), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    issue_miss(32'h1234_5678, 1'b0);
    mid();
    chk("t6_outst_after", 32'(outst), 32'd1);
    rlast_pulse();

    // Randomized traffic; RLAST only while the model has bursts in flight.
    for (int c = 0; c < 500; c++) begin
      tick();
      valid   = 1'($urandom_range(0, 1));
      addr    = $urandom;
      arready = ($urandom_range(0, 2) != 0);
      full    = ($urandom_range(0, 3) == 0);
      rvalid  = 1'($urandom_range(0, 1));
      rready  = 1'($urandom_range(0, 1));
      rlast   = (m_outst > 0) && ($urandom_range(0, 2) == 0);
    end

    // Drain.
    tick();
    valid = 1'b0; full = 1'b0; arready = 1'b1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    tick(); tick();
    arready = 1'b0;
    for (int i = 0; i < 20 && m_outst > 0; i++) rlast_pulse();
    mid();
    chk("drain_outst", 32'(outst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_miss_req_unit.md
Name: cc_miss_req_unit

Overview:
- Sits directly upstream of the cache data-fill stage, between the cache-miss detector and the AXI memory interface.
- For each accepted miss, issues one AXI read-address burst: 8 beats of 64 bits, WRAP, critical-word-first.
- In the same cycle, pushes the miss address into the miss-address FIFO that the fill stage pops on the first R beat.
- Bounds in-flight bursts by tracking R-channel last beats.

Parameters:
- MAX_OUTSTANDING, 4, maximum AR bursts issued whose RLAST has not yet been seen (1..15).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; do not override).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- miss_req_valid_i  input  1  miss request from the tag-compare stage
- miss_req_addr_i  input  32  byte address of the missing word
- miss_req_ready_o  output  1  request accepted when valid & ready
- mem_arvalid_o  output  1  AXI AR valid
- mem_araddr_o  output  32  AXI AR address, 8-byte aligned
- mem_arlen_o  output  4  AXI AR length, constant 4'd7
- mem_arsize_o  output  3  AXI AR size, constant 3'b011
- mem_arburst_o  output  2  AXI AR burst type, constant 2'b10 (WRAP)
- mem_arready_i  input  1  AXI AR ready
- mem_rvalid_i  input  1  AXI R valid (monitor only)
- mem_rready_i  input  1  AXI R ready (monitor only)
- mem_rlast_i  input  1  AXI R last (monitor only)
- miss_addr_fifo_full_i  input  1  miss-address FIFO full
- miss_addr_fifo_wren_o  output  1  miss-address FIFO push
- miss_addr_fifo_wdata_o  output  32  miss-address FIFO write data
- outstanding_o  output  CNT_W  current in-flight burst count (debug/perf)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; araddr register=0; outstanding=0.
  - Outputs: mem_arvalid_o=0, miss_addr_fifo_wren_o=0, miss_req_ready_o=0 while rst_n low.
  - Constant AR fields are driven regardless of reset.
- FSM has 2 states: IDLE, AR_REQ.
- IDLE:
  - miss_req_ready_o = (outstanding < MAX_OUTSTANDING) & ~miss_addr_fifo_full_i. Combinational; independent of miss_req_valid_i.
  - Accept = valid & ready. In the accept cycle, combinationally:
    - miss_addr_fifo_wren_o=1;
    - miss_addr_fifo_wdata_o = miss_req_addr_i, full 32 bits unmodified (the fill stage needs bits [5:3] for the wrap offset);
    - araddr register <= {miss_req_addr_i[31:3],3'b000};
    - next state AR_REQ.
  - miss_addr_fifo_wren_o=0 in every other cycle.
- AR_REQ:
  - mem_arvalid_o=1; mem_araddr_o=araddr register, held stable until handshake; miss_req_ready_o=0.
  - On mem_arready_i=1: outstanding increments; next state IDLE.
  - Otherwise remain in AR_REQ. arvalid is never dropped before handshake (AXI rule).
- Latency:
  - Accept in cycle N -> arvalid in cycle N+1.
  - Minimum 2 cycles per miss (no back-to-back accept while AR pending).
- Ordering: FIFO push order equals AR issue order, because pushes happen strictly one per AR and the FSM serialises them.
- Outstanding counter:
  - Decrements on mem_rvalid_i & mem_rready_i & mem_rlast_i.
  - Increment and decrement in the same cycle -> value unchanged.
  - Saturates at 0: an RLAST with outstanding=0 leaves it at 0; the bench flags this as a protocol error via assertion.
  - Never exceeds MAX_OUTSTANDING (guaranteed by the ready gating).
- Boundaries:
  - FIFO full in IDLE -> ready=0, no push, no AR.
  - FIFO full while in AR_REQ does not affect the pending AR.
  - outstanding==MAX -> ready=0 until an RLAST is seen. RLAST in the same cycle as valid makes ready=1 only from the next cycle, because the counter is registered.
- Reset mid-burst: all state cleared immediately. A pending AR is abandoned. Memory and the fill stage are reset by the same rst_n.
- Assertions: stable araddr while arvalid & ~arready; no wren when full; outstanding <= MAX_OUTSTANDING.

Decomposition:
- Shared package cc_pkg holds:
  - AXI constants: AXI_BURST_WRAP=2'b10, AXI_SIZE_8B=3'b011, LINE_ARLEN=4'd7;
  - address field slices: tag [31:15], index [14:6], word offset [5:3];
  - the FSM state enum typedef.
- Single flat module; no sub-module needed.

Test Plan:
- Single miss: addr 0x0001_2368, arready asserted after 3 cycles -> fifo push data 0x0001_2368 in accept cycle; araddr 0x0001_2368, arlen 7, arburst 2, arsize 3 held 3 cycles; outstanding 0->1; drive 8 R beats with rlast on 8th -> outstanding 0.
- Unaligned address 0x0000_0047 -> araddr 0x0000_0040, fifo data 0x0000_0047.
- Throttle: MAX_OUTSTANDING=4, five back-to-back misses, no R beats -> exactly 4 ARs, ready low on the 5th; one rlast -> 5th accepted next cycle.
- FIFO full held for 10 cycles with valid high -> no push, no arvalid; deassert full -> accept within 1 cycle.
- Simultaneous AR handshake and rlast at outstanding=2 -> outstanding stays 2.
- Assert rst_n=0 while arvalid=1 -> arvalid, wren and outstanding all 0 immediately (asynchronously); after release, a new miss proceeds normally.
